// File: rtl/ascii_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_pkg
//  Description : Shared constants and FSM state encoding for the serial
//                ASCII framing controller.
//  Revision    : 1.0  initial release
// ============================================================================
package ascii_pkg;

    // Width of one ASCII character on the serial line
    localparam int c_CHAR_W_ASCII = 7;

    // Default end-of-message character ('+')
    localparam logic [c_CHAR_W_ASCII-1:0] c_TERM_CHAR_DEFAULT = 7'h2B;

    // Controller state encoding
    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_SHIFT = 2'd1;
    localparam state_t c_ST_DRAIN = 2'd2;
    localparam state_t c_ST_DONE  = 2'd3;

endpackage : ascii_pkg
`default_nettype wire

// File: rtl/ascii_char_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_char_fifo
//  Description : Small synchronous first-word-fall-through FIFO. The head
//                entry is read straight from registered storage. Storage is
//                cleared on reset so the head reads zero while empty after
//                reset.
//  Revision    : 1.0  initial release
// ============================================================================
module ascii_char_fifo #(
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // Writes into a full FIFO and reads from an empty one are dropped
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop  & ~o_empty;

    assign o_full  = (r_count == c_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // Character storage; cleared on reset so the head output starts at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule : ascii_char_fifo
`default_nettype wire

// File: rtl/ascii_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_frame_ctrl
//  Description : Frames a serial MSB-first bit stream into 7-bit ASCII
//                characters, buffers them for a valid/ready consumer and
//                ends each message on a terminator char or a length cap.
//  Revision    : 1.0  initial release
// ============================================================================
module ascii_frame_ctrl
    import ascii_pkg::*;
#(
    parameter int                CHAR_W     = c_CHAR_W_ASCII,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [CHAR_W-1:0] TERM_CHAR  = c_TERM_CHAR_DEFAULT,
    parameter int                MAX_LEN    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           bit_in,
    input  logic                           bit_valid,
    output logic                           bit_ready,
    output logic [CHAR_W-1:0]              char_out,
    output logic                           char_valid,
    input  logic                           char_ready,
    output logic [$clog2(MAX_LEN+1)-1:0]   msg_len,
    output logic                           trunc,
    output logic                           msg_done
);

    localparam int c_BIT_CNT_W = $clog2(CHAR_W);
    localparam int c_LEN_W     = $clog2(MAX_LEN + 1);

    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT = c_BIT_CNT_W'(CHAR_W - 1);
    localparam logic [c_LEN_W-1:0]     c_MAX_LEN  = c_LEN_W'(MAX_LEN);

    state_t r_state;
    state_t w_state_nxt;

    logic [c_BIT_CNT_W-1:0] r_bit_cnt;
    logic [CHAR_W-2:0]      r_shreg;
    logic [c_LEN_W-1:0]     r_msg_len;
    logic                   r_trunc;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;
    logic               w_xfer;
    logic               w_last_bit;
    logic               w_push;
    logic [CHAR_W-1:0]  w_char;
    logic [c_LEN_W-1:0] w_len_inc;
    logic               w_is_term;
    logic               w_at_cap;
    logic               w_end_msg;
    logic               w_start_msg;

    // Datapath decode: the char completes on the bit that lands in the last slot
    assign w_xfer      = bit_valid & bit_ready;
    assign w_last_bit  = (r_bit_cnt == c_LAST_BIT);
    assign w_push      = w_xfer & w_last_bit;
    assign w_char      = {r_shreg, bit_in};
    assign w_len_inc   = r_msg_len + 1'b1;
    assign w_is_term   = (w_char == TERM_CHAR);
    assign w_at_cap    = (w_len_inc == c_MAX_LEN);
    assign w_end_msg   = w_push & (w_is_term | w_at_cap);
    assign w_start_msg = (r_state == c_ST_IDLE) & start;
    assign w_pop       = char_ready & ~w_fifo_empty;

    assign char_valid = ~w_fifo_empty;
    assign msg_len    = r_msg_len;
    assign trunc      = r_trunc;

    ascii_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CHAR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_char),
        .i_pop   (w_pop),
        .o_head  (char_out),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: message runs until terminator or cap, then waits for the FIFO to empty
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start)        w_state_nxt = c_ST_SHIFT;
            c_ST_SHIFT: if (w_end_msg)    w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_fifo_empty) w_state_nxt = c_ST_DONE;
            c_ST_DONE:                    w_state_nxt = c_ST_IDLE;
            default:                      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Outputs: stall only the completing bit when the FIFO is full (a same-cycle pop is not credited)
    always_comb begin
        bit_ready = 1'b0;
        msg_done  = 1'b0;
        case (r_state)
            c_ST_SHIFT: bit_ready = ~(w_last_bit & w_fifo_full);
            c_ST_DONE:  msg_done  = 1'b1;
            default: begin
                bit_ready = 1'b0;
                msg_done  = 1'b0;
            end
        endcase
    end

    // Bit counter and shift register; held through bit_valid gaps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shreg   <= '0;
        end else if (w_start_msg) begin
            r_bit_cnt <= '0;
        end else if (w_xfer) begin
            r_shreg   <= w_char[CHAR_W-2:0];
            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
        end
    end

    // Message length and sticky truncation flag; both hold after the message until the next start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_msg_len <= '0;
            r_trunc   <= 1'b0;
        end else if (w_start_msg) begin
            r_msg_len <= '0;
            r_trunc   <= 1'b0;
        end else if (w_push) begin
            r_msg_len <= w_len_inc;
            if (w_at_cap && !w_is_term) begin
                r_trunc <= 1'b1;
            end
        end
    end

endmodule : ascii_frame_ctrl
`default_nettype wire

// File: tb/tb_ascii_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ascii_frame_ctrl
//  Description : Directed self-checking bench for ascii_frame_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ascii_frame_ctrl;

    localparam int c_CHAR_W = 7;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic [6:0] char_out;
    logic       char_valid;
    logic       char_ready;
    logic [4:0] msg_len;
    logic       trunc;
    logic       msg_done;

    ascii_frame_ctrl #(
        .CHAR_W     (7),
        .FIFO_DEPTH (4),
        .TERM_CHAR  (7'h2B),
        .MAX_LEN    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .msg_len    (msg_len),
        .trunc      (trunc),
        .msg_done   (msg_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] tx[$];
    logic [6:0] exp_q[$];
    logic [6:0] rx[$];
    int         done_cnt  = 0;
    int         done_base = 0;

    bit release_on_stall = 0;
    bit stall_seen       = 0;
    int stall_char       = -1;
    int stall_bit        = -1;
    int cur_char         = 0;
    int cur_bit          = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Consumer side: record every pop and every msg_done cycle
    always @(posedge clk) begin
        if (rst_n) begin
            if (char_valid && char_ready) rx.push_back(char_out);
            if (msg_done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic load_hello();
        tx = '{7'h48, 7'h65, 7'h6C, 7'h6C, 7'h6F, 7'h5F,
               7'h57, 7'h6F, 7'h72, 7'h6C, 7'h64, 7'h2B};
        exp_q = tx;
    endtask

    task automatic load_hi();
        tx = '{7'h48, 7'h69, 7'h2B};
        exp_q = tx;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic begin_msg();
        rx.delete();
        done_base = done_cnt;
        pulse_start();
    endtask

    // Offer one bit, optionally after random idle cycles; bounded wait for acceptance
    task automatic send_bit(input logic b, input bit gaps);
        bit ok = 0;
        if (gaps) begin
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(0, 1) == 0) break;
                bit_valid = 1'b0;
                @(negedge clk);
            end
        end
        bit_in    = b;
        bit_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (bit_ready) begin
                @(posedge clk);
                @(negedge clk);
                ok = 1;
                break;
            end
            if (release_on_stall && !stall_seen) begin
                stall_seen = 1;
                stall_char = cur_char;
                stall_bit  = cur_bit;
                char_ready = 1'b1;
            end
            @(negedge clk);
        end
        bit_valid = 1'b0;
        if (!ok) check("bit_accept_timeout", 0, 1);
    endtask

    task automatic send_range(input int first, input int cnt, input bit gaps);
        for (int c = first; c < first + cnt; c++) begin
            for (int b = c_CHAR_W - 1; b >= 0; b--) begin
                cur_char = c;
                cur_bit  = c_CHAR_W - 1 - b;
                send_bit(tx[c][b], gaps);
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == done_base && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != done_base), 1);
        repeat (6) @(negedge clk);
        check({tag, "_done_once"}, 32'(done_cnt - done_base), 1);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_count"}, 32'(rx.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            check($sformatf("%s_char%0d", tag, i), 32'(rx[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bit_ready"},  32'(bit_ready),  0);
        check({tag, "_char_valid"}, 32'(char_valid), 0);
        check({tag, "_char_out"},   32'(char_out),   0);
        check({tag, "_msg_len"},    32'(msg_len),    0);
        check({tag, "_trunc"},      32'(trunc),      0);
        check({tag, "_msg_done"},   32'(msg_done),   0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst_n = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; char_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: full message, consumer always ready, first-char latency
        char_ready = 1'b1;
        load_hello();
        begin_msg();
        send_range(0, 1, 0);
        check("c1_first_valid", 32'(char_valid), 1);
        check("c1_first_char",  32'(char_out),   32'h48);
        send_range(1, 11, 0);
        wait_done("c1");
        check_rx("c1");
        check("c1_msg_len", 32'(msg_len), 12);
        check("c1_trunc",   32'(trunc),   0);

        // 2: consumer stalled until backpressure reaches the bit input
        char_ready = 1'b0;
        release_on_stall = 1;
        stall_seen = 0;
        load_hello();
        begin_msg();
        send_range(0, 12, 0);
        release_on_stall = 0;
        wait_done("c2");
        check("c2_stall_seen", 32'(stall_seen), 1);
        check("c2_stall_char", 32'(stall_char), 4);
        check("c2_stall_bit",  32'(stall_bit),  6);
        check_rx("c2");
        check("c2_msg_len", 32'(msg_len), 12);

        // 3: no terminator, message capped at 16 chars
        char_ready = 1'b1;
        tx.delete();
        for (int i = 0; i < 16; i++) tx.push_back(7'h41);
        exp_q = tx;
        begin_msg();
        send_range(0, 16, 0);
        check("c3_ready_after_cap", 32'(bit_ready), 0);
        acc = 0;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        for (int i = 0; i < 28; i++) begin
            if (bit_ready) acc++;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        check("c3_extra_bits_taken", 32'(acc), 0);
        wait_done("c3");
        check_rx("c3");
        check("c3_trunc",   32'(trunc),   1);
        check("c3_msg_len", 32'(msg_len), 16);

        // 4: reset mid-message discards everything
        char_ready = 1'b0;
        load_hi();
        begin_msg();
        send_range(0, 1, 0);
        check("c4_pre_reset_valid", 32'(char_valid), 1);
        send_bit(tx[1][6], 0);
        send_bit(tx[1][5], 0);
        send_bit(tx[1][4], 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("c4_after_reset");
        char_ready = 1'b1;
        begin_msg();
        send_range(0, 3, 0);
        wait_done("c4");
        check_rx("c4");
        check("c4_msg_len", 32'(msg_len), 3);

        // 5: random bit_valid gaps
        char_ready = 1'b1;
        load_hello();
        begin_msg();
        send_range(0, 12, 1);
        wait_done("c5");
        check_rx("c5");
        check("c5_msg_len", 32'(msg_len), 12);
        check("c5_trunc",   32'(trunc),   0);

        // 6: start pulses while busy are ignored
        char_ready = 1'b0;
        load_hi();
        begin_msg();
        send_range(0, 1, 0);
        pulse_start();
        check("c6_len_after_shift_start", 32'(msg_len), 1);
        send_range(1, 2, 0);
        pulse_start();
        check("c6_len_after_drain_start", 32'(msg_len), 3);
        check("c6_valid_in_drain", 32'(char_valid), 1);
        char_ready = 1'b1;
        wait_done("c6");
        check_rx("c6");
        check("c6_msg_len", 32'(msg_len), 3);
        check("c6_idle_ready", 32'(bit_ready), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ascii_frame_ctrl
`default_nettype wire
